// File: rtl/capt_byte_packer_pkg.sv
// Shared definitions for the capture byte packer: FIFO word layout, sideband
// bit positions, state encoding and the lane assembly helper.
package capt_byte_packer_pkg;

    localparam int CAPT_DSIZE   = 36;
    localparam int CAPT_SB_RSVD = 32;
    localparam int CAPT_SB_EOL  = 33;
    localparam int CAPT_SB_SOF  = 34;
    localparam int CAPT_SB_EOF  = 35;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } capt_state_t;

    // Lanes below k come from the stored lanes, lane k is the byte arriving
    // now, lanes above k are padding. A full word is simply the k == 3 case.
    function automatic logic [31:0] assemble_word(
        input logic [2:0][7:0] lanes,
        input logic [7:0]      cur,
        input logic [1:0]      k,
        input logic [7:0]      pad
    );
        logic [31:0] w;
        w = {4{pad}};
        for (int i = 0; i < 3; i++) begin
            if (i < int'(k)) begin
                w[8*i +: 8] = lanes[i];
            end
        end
        case (k)
            2'd0:    w[7:0]   = cur;
            2'd1:    w[15:8]  = cur;
            2'd2:    w[23:16] = cur;
            default: w[31:24] = cur;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/capt_byte_packer.sv
// Gates one camera frame per arm command and packs its bytes four at a time
// into 36-bit FIFO words with SOF/EOL/EOF sideband and per-capture status.
module capt_byte_packer
    import capt_byte_packer_pkg::*;
#(
    parameter int          DSIZE    = CAPT_DSIZE,
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int          CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capt_start,
    input  logic             capt_abort,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic             in_eof,
    input  logic             cfifo_afull,
    output logic             cfifo_wr_en,
    output logic [DSIZE-1:0] cfifo_wr_data,
    output logic             capt_busy,
    output logic             capt_done,
    output logic             capt_err_sof,
    output logic [CNT_W-1:0] capt_word_cnt,
    output logic [1:0]       capt_pad_cnt
);

    capt_state_t       state_q, state_d;
    logic [1:0]        lane_cnt_q, lane_cnt_d;
    logic [2:0][7:0]   lanes_q, lanes_d;
    logic              word_sof_q, word_sof_d;
    logic              word_eol_q, word_eol_d;
    logic              wr_en_q, wr_en_d;
    logic [DSIZE-1:0]  wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_sof_q, err_sof_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        pad_cnt_q, pad_cnt_d;

    logic              accepting;
    logic              beat;
    logic              emit;
    logic              emit_last;
    logic              sof_acc;
    logic              eol_acc;
    logic [31:0]       word_data;

    assign accepting = (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
    assign in_rdy    = accepting && !cfifo_afull;
    assign beat      = in_vld && in_rdy;

    // lane_cnt_q is held at 0 outside CAPTURE, so the SOF beat lands in lane 0.
    assign word_data = assemble_word(lanes_q, in_data, lane_cnt_q, PAD_BYTE);
    assign sof_acc   = word_sof_q || (in_sof && (lane_cnt_q == 2'd0));
    assign eol_acc   = word_eol_q || in_eol;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        lanes_d    = lanes_q;
        word_sof_d = word_sof_q;
        word_eol_d = word_eol_q;
        done_d     = done_q;
        err_sof_d  = err_sof_q;
        pad_cnt_d  = pad_cnt_q;
        emit       = 1'b0;
        emit_last  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (capt_start) begin
                    state_d    = ST_WAIT_SOF;
                    lane_cnt_d = 2'd0;
                    word_sof_d = 1'b0;
                    word_eol_d = 1'b0;
                    done_d     = 1'b0;
                    err_sof_d  = 1'b0;
                    pad_cnt_d  = 2'd0;
                end
            end

            ST_WAIT_SOF: begin
                if (capt_abort) begin
                    state_d = ST_IDLE;
                end else if (beat && in_sof) begin
                    if (in_eof) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        pad_cnt_d = 2'd3;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        lanes_d[0] = in_data;
                        lane_cnt_d = 2'd1;
                        word_sof_d = 1'b1;
                        word_eol_d = in_eol;
                        state_d    = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (capt_abort) begin
                    state_d    = ST_IDLE;
                    lane_cnt_d = 2'd0;
                    word_sof_d = 1'b0;
                    word_eol_d = 1'b0;
                end else if (beat) begin
                    // A mid-frame SOF closes the frame just like an EOF, but flags an error.
                    if (in_sof || in_eof) begin
                        emit       = 1'b1;
                        emit_last  = 1'b1;
                        pad_cnt_d  = 2'd3 - lane_cnt_q;
                        err_sof_d  = err_sof_q || in_sof;
                        done_d     = 1'b1;
                        lane_cnt_d = 2'd0;
                        word_sof_d = 1'b0;
                        word_eol_d = 1'b0;
                        state_d    = ST_DONE;
                    end else if (lane_cnt_q == 2'd3) begin
                        emit       = 1'b1;
                        lane_cnt_d = 2'd0;
                        word_sof_d = 1'b0;
                        word_eol_d = 1'b0;
                    end else begin
                        case (lane_cnt_q)
                            2'd0:    lanes_d[0] = in_data;
                            2'd1:    lanes_d[1] = in_data;
                            default: lanes_d[2] = in_data;
                        endcase
                        lane_cnt_d = lane_cnt_q + 2'd1;
                        word_eol_d = eol_acc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_en_d    = emit;
        wr_data_d  = wr_data_q;
        word_cnt_d = word_cnt_q;
        if ((state_q == ST_IDLE || state_q == ST_DONE) && capt_start) begin
            word_cnt_d = '0;
        end
        if (emit) begin
            wr_data_d                = '0;
            wr_data_d[31:0]          = word_data;
            wr_data_d[CAPT_SB_RSVD]  = 1'b0;
            wr_data_d[CAPT_SB_EOL]   = eol_acc;
            wr_data_d[CAPT_SB_SOF]   = sof_acc;
            wr_data_d[CAPT_SB_EOF]   = emit_last;
            if (word_cnt_q != {CNT_W{1'b1}}) begin
                word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= 2'd0;
            lanes_q    <= '0;
            word_sof_q <= 1'b0;
            word_eol_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_sof_q  <= 1'b0;
            word_cnt_q <= '0;
            pad_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            lanes_q    <= lanes_d;
            word_sof_q <= word_sof_d;
            word_eol_q <= word_eol_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_sof_q  <= err_sof_d;
            word_cnt_q <= word_cnt_d;
            pad_cnt_q  <= pad_cnt_d;
        end
    end

    assign cfifo_wr_en   = wr_en_q;
    assign cfifo_wr_data = wr_data_q;
    assign capt_busy     = accepting;
    assign capt_done     = done_q;
    assign capt_err_sof  = err_sof_q;
    assign capt_word_cnt = word_cnt_q;
    assign capt_pad_cnt  = pad_cnt_q;

endmodule

// File: tb/tb_capt_byte_packer.sv
// Self-checking bench for capt_byte_packer: directed frames plus randomized
// frames, all compared against a frame-level chunking model.
module tb_capt_byte_packer;

    localparam int          DSIZE = 36;
    localparam int          CNT_W = 24;
    localparam logic [7:0]  PAD   = 8'h00;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         eol;
        bit         eof;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             capt_start;
    logic             capt_abort;
    logic             in_vld;
    logic             in_rdy;
    logic [7:0]       in_data;
    logic             in_sof;
    logic             in_eol;
    logic             in_eof;
    logic             cfifo_afull;
    logic             cfifo_wr_en;
    logic [DSIZE-1:0] cfifo_wr_data;
    logic             capt_busy;
    logic             capt_done;
    logic             capt_err_sof;
    logic [CNT_W-1:0] capt_word_cnt;
    logic [1:0]       capt_pad_cnt;

    beat_t            stim[$];
    logic [DSIZE-1:0] got[$];
    logic [DSIZE-1:0] expw[$];
    int               exp_pad;
    bit               exp_err;
    int               vectors    = 0;
    int               miscompares = 0;
    bit               rand_afull = 0;

    capt_byte_packer #(.DSIZE(DSIZE), .PAD_BYTE(PAD), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .capt_start    (capt_start),
        .capt_abort    (capt_abort),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_data       (in_data),
        .in_sof        (in_sof),
        .in_eol        (in_eol),
        .in_eof        (in_eof),
        .cfifo_afull   (cfifo_afull),
        .cfifo_wr_en   (cfifo_wr_en),
        .cfifo_wr_data (cfifo_wr_data),
        .capt_busy     (capt_busy),
        .capt_done     (capt_done),
        .capt_err_sof  (capt_err_sof),
        .capt_word_cnt (capt_word_cnt),
        .capt_pad_cnt  (capt_pad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cfifo_wr_en) got.push_back(cfifo_wr_data);
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_afull) cfifo_afull = ($urandom_range(0, 2) == 0);
    endtask

    task automatic pulseStart();
        capt_start = 1'b1;
        tick();
        capt_start = 1'b0;
    endtask

    task automatic sendByte(input beat_t b);
        bit accepted;
        accepted = 1'b0;
        in_vld  = 1'b1;
        in_data = b.d;
        in_sof  = b.sof;
        in_eol  = b.eol;
        in_eof  = b.eof;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            accepted = in_rdy;
            tick();
        end
        checkOutput("beat_accept", {63'd0, accepted}, 64'd1);
    endtask

    task automatic idleInputs();
        in_vld = 1'b0;
        in_sof = 1'b0;
        in_eol = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic applyStimulus(input int first, input int last);
        for (int i = first; i <= last; i++) sendByte(stim[i]);
        idleInputs();
    endtask

    // Reference: find the frame (SOF .. EOF or a second SOF), then cut it into 4-byte words.
    task automatic buildExpected();
        beat_t            fb[$];
        bit               inframe;
        int               nwords;
        logic [DSIZE-1:0] w;
        inframe = 1'b0;
        exp_err = 1'b0;
        expw.delete();
        foreach (stim[i]) begin
            if (!inframe) begin
                if (stim[i].sof) begin
                    inframe = 1'b1;
                    fb.push_back(stim[i]);
                    if (stim[i].eof) break;
                end
            end else begin
                fb.push_back(stim[i]);
                if (stim[i].sof) begin
                    exp_err = 1'b1;
                    break;
                end
                if (stim[i].eof) break;
            end
        end
        nwords  = (fb.size() + 3) / 4;
        exp_pad = nwords * 4 - fb.size();
        for (int wi = 0; wi < nwords; wi++) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * wi + l < fb.size()) begin
                    w[8*l +: 8] = fb[4*wi+l].d;
                    if (fb[4*wi+l].eol) w[33] = 1'b1;
                end else begin
                    w[8*l +: 8] = PAD;
                end
            end
            w[34] = fb[4*wi].sof;
            w[35] = (wi == nwords - 1);
            expw.push_back(w);
        end
    endtask

    task automatic checkFrame(input string name, input int base);
        repeat (3) tick();
        checkOutput({name, "_nwords"}, 64'(got.size() - base), 64'(expw.size()));
        for (int i = 0; i < expw.size(); i++) begin
            if (base + i < got.size()) checkOutput({name, "_word"}, 64'(got[base+i]), 64'(expw[i]));
        end
        checkOutput({name, "_done"},     64'(capt_done),     64'd1);
        checkOutput({name, "_busy"},     64'(capt_busy),     64'd0);
        checkOutput({name, "_pad"},      64'(capt_pad_cnt),  64'(exp_pad));
        checkOutput({name, "_err_sof"},  64'(capt_err_sof),  64'(exp_err));
        checkOutput({name, "_word_cnt"}, 64'(capt_word_cnt), 64'(expw.size()));
    endtask

    function automatic beat_t mk(input logic [7:0] d, input bit sof, input bit eol, input bit eof);
        beat_t b;
        b.d = d; b.sof = sof; b.eol = eol; b.eof = eof;
        return b;
    endfunction

    initial begin
        int base;
        int base2;
        int len;
        int junk;
        rst_n       = 1'b0;
        capt_start  = 1'b0;
        capt_abort  = 1'b0;
        cfifo_afull = 1'b0;
        in_data     = 8'h00;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_en",    64'(cfifo_wr_en),   64'd0);
        checkOutput("rst_wr_data",  64'(cfifo_wr_data), 64'd0);
        checkOutput("rst_busy",     64'(capt_busy),     64'd0);
        checkOutput("rst_done",     64'(capt_done),     64'd0);
        checkOutput("rst_word_cnt", 64'(capt_word_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        in_vld = 1'b1;
        @(negedge clk);
        checkOutput("idle_rdy", 64'(in_rdy), 64'd0);
        tick();
        idleInputs();

        // Full 16-byte frame
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(mk(8'(i), i == 0, 1'b0, i == 15));
        buildExpected();
        base = got.size();
        pulseStart();
        checkOutput("armed_busy", 64'(capt_busy), 64'd1);
        applyStimulus(0, stim.size() - 1);
        checkFrame("full", base);
        if (got.size() >= base + 4) begin
            checkOutput("full_first_const", 64'(got[base]),   64'h4_0302_0100);
            checkOutput("full_last_const",  64'(got[base+3]), 64'h8_0F0E_0D0C);
        end

        // Padded 6-byte frame
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(mk(8'hA0 + 8'(i), i == 0, 1'b0, i == 5));
        buildExpected();
        base = got.size();
        pulseStart();
        checkOutput("rearm_done_clr", 64'(capt_done), 64'd0);
        applyStimulus(0, stim.size() - 1);
        checkFrame("padded", base);
        if (got.size() >= base + 2) checkOutput("padded_const", 64'(got[base+1]), 64'h8_0000_A5A4);

        // Junk before SOF, EOL inside the first word
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(mk(8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) stim.push_back(mk(8'h10 + 8'(i), i == 0, i == 2, i == 9));
        buildExpected();
        base = got.size();
        pulseStart();
        applyStimulus(0, stim.size() - 1);
        checkFrame("presof", base);
        if (got.size() > base) checkOutput("presof_sb", 64'(got[base][35:32]), 64'h6);

        // Backpressure for 10 cycles right after a word completes
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(mk(8'h30 + 8'(i), i == 0, i == 7, i == 11));
        buildExpected();
        base = got.size();
        pulseStart();
        applyStimulus(0, 3);
        in_vld = 1'b1;
        cfifo_afull = 1'b1;
        base2 = got.size();
        in_data = stim[4].d;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_rdy", 64'(in_rdy), 64'd0);
            tick();
        end
        checkOutput("bp_writes", 64'(got.size() - base2), 64'd1);
        cfifo_afull = 1'b0;
        applyStimulus(4, stim.size() - 1);
        checkFrame("bp", base);

        // Abort after 3 bytes, then a clean frame
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(mk(8'h50 + 8'(i), i == 0, 1'b0, 1'b0));
        base = got.size();
        pulseStart();
        applyStimulus(0, 2);
        capt_abort = 1'b1;
        tick();
        capt_abort = 1'b0;
        repeat (3) tick();
        checkOutput("abort_nowrite", 64'(got.size() - base), 64'd0);
        checkOutput("abort_busy",    64'(capt_busy),         64'd0);
        checkOutput("abort_done",    64'(capt_done),         64'd0);
        stim.delete();
        for (int i = 0; i < 9; i++) stim.push_back(mk(8'h60 + 8'(i), i == 0, 1'b0, i == 8));
        buildExpected();
        base = got.size();
        pulseStart();
        applyStimulus(0, stim.size() - 1);
        checkFrame("post_abort", base);

        // Randomized frames with random almost-full
        for (int f = 0; f < 6; f++) begin
            stim.delete();
            junk = $urandom_range(0, 3);
            len  = $urandom_range(1, 20);
            for (int i = 0; i < junk; i++) stim.push_back(mk(8'($urandom), 1'b0, ($urandom_range(0, 3) == 0), 1'b0));
            for (int i = 0; i < len; i++)
                stim.push_back(mk(8'($urandom), i == 0, ($urandom_range(0, 3) == 0), i == len - 1));
            buildExpected();
            base = got.size();
            rand_afull = 1'b1;
            pulseStart();
            applyStimulus(0, stim.size() - 1);
            rand_afull = 1'b0;
            cfifo_afull = 1'b0;
            checkFrame("rand", base);
        end

        // Second SOF on byte 5 closes the frame with an error
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(mk(8'h70 + 8'(i), i == 0 || i == 5, 1'b0, 1'b0));
        buildExpected();
        base = got.size();
        pulseStart();
        applyStimulus(0, stim.size() - 1);
        checkFrame("midsof", base);
        pulseStart();
        checkOutput("midsof_err_clr", 64'(capt_err_sof),  64'd0);
        checkOutput("rearm_cnt_clr",  64'(capt_word_cnt), 64'd0);

        // Asynchronous reset in the middle of a word
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(mk(8'h80 + 8'(i), i == 0, 1'b0, 1'b0));
        applyStimulus(0, 5);
        in_vld = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_wr_en",    64'(cfifo_wr_en),   64'd0);
        checkOutput("arst_wr_data",  64'(cfifo_wr_data), 64'd0);
        checkOutput("arst_busy",     64'(capt_busy),     64'd0);
        checkOutput("arst_rdy",      64'(in_rdy),        64'd0);
        checkOutput("arst_word_cnt", 64'(capt_word_cnt), 64'd0);
        checkOutput("arst_pad",      64'(capt_pad_cnt),  64'd0);
        idleInputs();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
